// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter and the ALU opcode decode.
//   - 3-bit opcode type and the opcodes the ALU implements
//   - is_legal_op(): 1 for opcodes the ALU implements
//   - arbiter FSM state encoding
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_FADD = 3'b000;
  localparam op_t OP_FSUB = 3'b001;
  localparam op_t OP_FMUL = 3'b011;
  localparam op_t OP_AND  = 3'b100;
  localparam op_t OP_OR   = 3'b101;
  localparam op_t OP_XOR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // 010 and 111 have no ALU implementation.
  function automatic logic is_legal_op(input op_t op);
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels and the ALU operand/result bus.
//   req{0,1}_valid/ready/op/a/b : request channels (requester -> arbiter)
//   rsp{0,1}_valid/ready/data/err : response channels (arbiter -> requester)
//   alu_opcode/alu_x1/alu_x2 : arbiter -> ALU, alu_x3 : ALU -> arbiter
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              req0_valid;
  logic              req0_ready;
  alu_pkg::op_t      req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  alu_pkg::op_t      req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  alu_pkg::op_t      alu_opcode;
  logic [DATA_W-1:0] alu_x1;
  logic [DATA_W-1:0] alu_x2;
  logic [DATA_W-1:0] alu_x3;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output alu_opcode, alu_x1, alu_x2,
    input  alu_x3
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  alu_opcode, alu_x1, alu_x2,
    output alu_x3
  );

endinterface

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: combinational 2-way round-robin grant.
//   valid0/valid1 : requests
//   last_grant    : port that completed most recently (0 or 1)
//   grant0/grant1 : one-hot (or zero) grant
// A lone request is always granted; on contention the port != last_grant wins.
module alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two valid/ready requesters.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; discards any in-flight operation
//   bus  : alu_arbiter_if.slave -- both request/response channels and the ALU bus
//   busy : high whenever the FSM is not IDLE
// One operation is in flight at a time. Legal opcodes spend ALU_LATENCY+1 cycles in
// EXEC before the result is captured; illegal opcodes go straight to RESP with err=1.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned DATA_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  op_t               alu_op_q;
  logic [DATA_W-1:0] alu_x1_q;
  logic [DATA_W-1:0] alu_x2_q;

  logic              grant0;
  logic              grant1;
  logic              ready0;
  logic              ready1;
  logic              xfer;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic              rsp_fire;
  op_t               sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  alu_rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_comb begin
    // Ready is masked during reset so nobody sees a transfer the FSM will ignore.
    ready0     = (state == IDLE) & ~rst & grant0;
    ready1     = (state == IDLE) & ~rst & grant1;
    xfer       = ready0 | ready1;  // a grant already implies the matching valid
    sel_op     = grant1 ? bus.req1_op : bus.req0_op;
    sel_a      = grant1 ? bus.req1_a  : bus.req0_a;
    sel_b      = grant1 ? bus.req1_b  : bus.req0_b;
    rsp_valid0 = (state == RESP) & ~owner;
    rsp_valid1 = (state == RESP) &  owner;
    rsp_fire   = (rsp_valid0 & bus.rsp0_ready) | (rsp_valid1 & bus.rsp1_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      alu_op_q   <= '0;
      alu_x1_q   <= '0;
      alu_x2_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            owner <= grant1;
            if (is_legal_op(sel_op)) begin
              // The ALU operand registers double as the latched request.
              alu_op_q <= sel_op;
              alu_x1_q <= sel_a;
              alu_x2_q <= sel_b;
              cnt      <= 4'(ALU_LATENCY);
              state    <= EXEC;
            end else begin
              res_data <= '0;
              res_err  <= 1'b1;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_data <= bus.alu_x3;
            res_err  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = rsp_valid0;
  assign bus.rsp1_valid = rsp_valid1;
  assign bus.rsp0_data  = res_data;
  assign bus.rsp1_data  = res_data;
  assign bus.rsp0_err   = rsp_valid0 & res_err;
  assign bus.rsp1_err   = rsp_valid1 & res_err;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_x1     = alu_x1_q;
  assign bus.alu_x2     = alu_x2_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Four DUTs (ALU_LATENCY 1, 3, 0, 4) share the
// stimulus; sel routes request valids to one DUT and its outputs back to the checks.
// Each DUT has its own ALU model that returns 32'hDEAD_DEAD until its inputs have
// been stable for ALU_LATENCY cycles.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  op_t         req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  typedef struct packed {
    logic        req0_ready;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        rsp1_err;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_x1;
    logic [31:0] alu_x2;
    logic        busy;
  } mon_t;

  mon_t mon [4];
  mon_t o;
  assign o = mon[sel];

  function automatic logic [31:0] alu_f(input op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_FADD: return (a == 32'h0) ? b : ((b == 32'h0) ? a : 32'h7FC0_0000);
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g
    localparam int unsigned Lat = (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 0 : 4;
    alu_arbiter_if #(.DATA_W(32)) bus ();
    logic busy;

    alu_arbiter #(.ALU_LATENCY(Lat), .DATA_W(32)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
    );

    assign bus.req0_valid = req0_valid & (sel == i);
    assign bus.req1_valid = req1_valid & (sel == i);
    assign bus.req0_op    = req0_op;
    assign bus.req0_a     = req0_a;
    assign bus.req0_b     = req0_b;
    assign bus.req1_op    = req1_op;
    assign bus.req1_a     = req1_a;
    assign bus.req1_b     = req1_b;
    assign bus.rsp0_ready = rsp0_ready;
    assign bus.rsp1_ready = rsp1_ready;

    assign mon[i] = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp0_data,
                     bus.rsp0_err, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err,
                     bus.alu_opcode, bus.alu_x1, bus.alu_x2, busy};

    // ALU model: age counts cycles the operand tuple has been stable.
    logic [66:0] hist = '1;
    int unsigned age  = 0;
    always @(posedge clk) begin
      if ({bus.alu_opcode, bus.alu_x1, bus.alu_x2} == hist) begin
        if (age < 100) age <= age + 1;
      end else begin
        hist <= {bus.alu_opcode, bus.alu_x1, bus.alu_x2};
        age  <= 1;
      end
    end
    always_comb begin
      if (Lat == 0 || ({bus.alu_opcode, bus.alu_x1, bus.alu_x2} == hist && age >= Lat))
        bus.alu_x3 = alu_f(bus.alu_opcode, bus.alu_x1, bus.alu_x2);
      else
        bus.alu_x3 = 32'hDEAD_DEAD;
    end
  end

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  localparam logic [31:0] A = 32'hFF80_01C0;
  localparam logic [31:0] B = 32'hFF80_2004;

  initial begin
    bit seen;

    // Reset state
    do_reset();
    #1;
    check("rst_busy", o.busy, 0);
    check("rst_req0_ready", o.req0_ready, 0);
    check("rst_req1_ready", o.req1_ready, 0);
    check("rst_rsp0_valid", o.rsp0_valid, 0);
    check("rst_rsp0_err", o.rsp0_err, 0);
    check("rst_rsp0_data", o.rsp0_data, 0);
    check("rst_alu_opcode", o.alu_opcode, 0);
    check("rst_alu_x1", o.alu_x1, 0);

    // 1. Single AND, latency 1
    tick();
    req0_valid = 1; req0_op = OP_AND; req0_a = A; req0_b = B; rsp0_ready = 1;
    #1;
    check("t1_c0_ready", o.req0_ready, 1);
    check("t1_c0_busy", o.busy, 0);
    tick(); req0_valid = 0; #1;
    check("t1_c1_opcode", o.alu_opcode, 3'b100);
    check("t1_c1_x1", o.alu_x1, A);
    check("t1_c1_busy", o.busy, 1);
    tick(); #1;
    check("t1_c2_opcode", o.alu_opcode, 3'b100);
    check("t1_c2_rsp_valid", o.rsp0_valid, 0);
    tick(); #1;
    check("t1_c3_rsp_valid", o.rsp0_valid, 1);
    check("t1_c3_rsp_data", o.rsp0_data, 32'hFF80_0000);
    check("t1_c3_rsp_err", o.rsp0_err, 0);
    check("t1_c3_busy", o.busy, 1);
    tick(); #1;
    check("t1_c4_rsp_valid", o.rsp0_valid, 0);
    check("t1_c4_busy", o.busy, 0);

    // 2. Contention from reset
    req0_valid = 1; req0_op = OP_OR;  req0_a = A; req0_b = B;
    req1_valid = 1; req1_op = OP_XOR; req1_a = A; req1_b = B;
    rsp0_ready = 1; rsp1_ready = 1;
    do_reset();
    #1;
    check("t2_first_req0_ready", o.req0_ready, 1);
    check("t2_first_req1_ready", o.req1_ready, 0);
    tick(); tick(); tick(); #1;
    check("t2_rsp0_valid", o.rsp0_valid, 1);
    check("t2_rsp0_data", o.rsp0_data, 32'hFF80_21C4);
    check("t2_resp_req1_ready", o.req1_ready, 0);
    tick(); #1;
    check("t2_second_req1_ready", o.req1_ready, 1);
    check("t2_second_req0_ready", o.req0_ready, 0);
    tick(); tick(); tick(); #1;
    check("t2_rsp1_valid", o.rsp1_valid, 1);
    check("t2_rsp1_data", o.rsp1_data, 32'h0000_21C4);
    check("t2_rsp1_only", o.rsp0_valid, 0);
    tick(); #1;
    check("t2_third_req0_ready", o.req0_ready, 1);
    check("t2_third_req1_ready", o.req1_ready, 0);
    tick(); req0_valid = 0; req1_valid = 0;
    tick(); tick(); #1;
    check("t2_third_rsp0_data", o.rsp0_data, 32'hFF80_21C4);
    tick(); #1;
    check("t2_idle", o.busy, 0);

    // 3. Backpressure on port 1 while port 0 waits
    tick();
    req1_valid = 1; req1_op = OP_XOR; rsp1_ready = 0;
    req0_valid = 1; req0_op = OP_AND;
    #1;
    check("t3_req1_ready", o.req1_ready, 1);
    check("t3_req0_blocked", o.req0_ready, 0);
    tick(); req1_valid = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check("t3_hold_valid", o.rsp1_valid, 1);
      check("t3_hold_data", o.rsp1_data, 32'h0000_21C4);
      check("t3_hold_req0", o.req0_ready, 0);
    end
    tick(); rsp1_ready = 1; #1;
    check("t3_release_valid", o.rsp1_valid, 1);
    tick(); #1;
    check("t3_after_valid", o.rsp1_valid, 0);
    check("t3_after_busy", o.busy, 0);
    check("t3_req0_now", o.req0_ready, 1);
    tick(); req0_valid = 0;
    tick(); tick(); #1;
    check("t3_and_data", o.rsp0_data, 32'hFF80_0000);
    tick();

    // 4. Illegal opcode
    req0_valid = 1; req0_op = 3'b111; req0_a = 32'h1234_5678; req0_b = 32'h9ABC_DEF0;
    #1;
    check("t4_ready", o.req0_ready, 1);
    tick(); req0_valid = 0; #1;
    check("t4_rsp_valid", o.rsp0_valid, 1);
    check("t4_rsp_err", o.rsp0_err, 1);
    check("t4_rsp_data", o.rsp0_data, 0);
    check("t4_opcode_kept", o.alu_opcode, 3'b100);
    check("t4_x1_kept", o.alu_x1, A);
    tick(); #1;
    check("t4_done_valid", o.rsp0_valid, 0);
    check("t4_done_busy", o.busy, 0);

    // 5. Reset in the 2nd EXEC cycle, latency 3
    tick();
    sel = 2'd1;
    req0_valid = 1; req0_op = OP_FMUL; req0_a = 32'h4234_851F; req0_b = 32'h427C_851F;
    #1;
    check("t5_ready", o.req0_ready, 1);
    tick(); req0_valid = 0; #1;
    check("t5_exec_opcode", o.alu_opcode, 3'b011);
    tick(); rst = 1; #1;
    check("t5_exec_x2", o.alu_x2, 32'h427C_851F);
    tick(); rst = 0; #1;
    check("t5_rst_busy", o.busy, 0);
    check("t5_rst_opcode", o.alu_opcode, 0);
    check("t5_rst_x1", o.alu_x1, 0);
    check("t5_rst_x2", o.alu_x2, 0);
    check("t5_rst_rsp_valid", o.rsp0_valid, 0);
    check("t5_rst_rsp_data", o.rsp0_data, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      if (o.rsp0_valid) seen = 1;
    end
    check("t5_no_response", seen, 0);
    tick();
    req0_valid = 1; req0_op = OP_AND; req0_a = A; req0_b = B;
    #1;
    check("t5_and_ready", o.req0_ready, 1);
    tick(); req0_valid = 0;
    tick(); tick(); tick(); #1;
    check("t5_and_c4_valid", o.rsp0_valid, 0);
    tick(); #1;
    check("t5_and_c5_valid", o.rsp0_valid, 1);
    check("t5_and_data", o.rsp0_data, 32'hFF80_0000);
    tick();

    // 6a. Latency 0
    sel = 2'd2;
    req0_valid = 1; req0_op = OP_FADD; req0_a = 32'h0; req0_b = 32'h7F80_0000;
    #1;
    check("t6a_ready", o.req0_ready, 1);
    tick(); req0_valid = 0; #1;
    check("t6a_exec_busy", o.busy, 1);
    check("t6a_exec_valid", o.rsp0_valid, 0);
    tick(); #1;
    check("t6a_rsp_valid", o.rsp0_valid, 1);
    check("t6a_rsp_data", o.rsp0_data, 32'h7F80_0000);
    tick(); #1;
    check("t6a_idle", o.busy, 0);

    // 6b. Latency 4
    tick();
    sel = 2'd3;
    req0_valid = 1;
    #1;
    check("t6b_ready", o.req0_ready, 1);
    tick(); req0_valid = 0; #1;
    check("t6b_c1_valid", o.rsp0_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("t6b_exec_valid", o.rsp0_valid, 0);
    end
    tick(); #1;
    check("t6b_rsp_valid", o.rsp0_valid, 1);
    check("t6b_rsp_data", o.rsp0_data, 32'h7F80_0000);
    check("t6b_rsp_err", o.rsp0_err, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
